// File: rtl/memory_mmio_ctrl.sv
// ============================================================================
// memory_mmio_ctrl: unified instruction/data storage plus MMIO registers behind
// one fixed-latency request/response handshake. Optional macro: IMEM_WP_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module memory_mmio_ctrl #(
  parameter int BUS_WIDTH  = 32,
  parameter int MEM_BYTES  = 128,
  parameter int IMEM_BYTES = 32,
  parameter int MMIO_BASE  = 120,
  parameter int MMIO_CH    = 2,
  parameter int RD_LAT     = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         wr_en,
  input  logic [BUS_WIDTH-1:0]         address,
  input  logic [BUS_WIDTH-1:0]         in_data,
  input  logic [1:0]                   mem_size,
  input  logic                         sz_ex,
  output logic                         resp_valid,
  output logic [BUS_WIDTH-1:0]         out_data,
  output logic                         err,
  output logic [BUS_WIDTH*MMIO_CH-1:0] mem_map_io,
  output logic [MMIO_CH-1:0]           mmio_wr_strb
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int SW = (MMIO_BASE > 1) ? $clog2(MMIO_BASE) : 1;
  localparam logic [31:0] MMIO_END = 32'(MMIO_BASE + 4 * MMIO_CH);

  logic [1:0]                   state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [31:0]                  addr_q, wdata_q, rdata_q;
  logic [1:0]                   size_q;
  logic                         sx_q, wr_q, err_q;
  logic [32*MMIO_CH-1:0]        mmio_q;
  logic [MMIO_CH-1:0]           strb_q;
  logic [7:0]                   mem_q [MMIO_BASE];

  logic                         w_is_imem, w_is_mmio, w_wp_fault, w_fault;
  logic                         w_done, w_commit;
  logic [1:0]                   w_size;
  logic [MMIO_CH-1:0]           w_ch_hit;
  logic [31:0]                  w_mmio_rd, w_ld, w_rdata;
  logic [SW-1:0]                w_idx [4];
  logic [7:0]                   w_rb  [4];

  assign w_is_imem = addr_q < 32'(IMEM_BYTES);

`ifdef IMEM_WP_EN
  assign w_wp_fault = wr_q && w_is_imem;
`else
  assign w_wp_fault = 1'b0;
`endif

  always_comb begin
    w_mmio_rd = '0;
    for (int i = 0; i < MMIO_CH; i++) begin
      w_ch_hit[i] = addr_q[31:2] == 30'((MMIO_BASE >> 2) + i);
      if (w_ch_hit[i]) w_mmio_rd = mmio_q[32*i +: 32];
    end
  end
  assign w_is_mmio = |w_ch_hit;

  // Instruction-region loads are always full words regardless of mem_size.
  assign w_size = (w_is_imem && !wr_q) ? 2'b10 : size_q;

  // addr >= MMIO_END covers both the unmapped hole and the out-of-range space.
  assign w_fault = (addr_q >= MMIO_END) || (w_size == 2'b11)
                || (w_size == 2'b01 && addr_q[0])
                || (w_size == 2'b10 && addr_q[1:0] != 2'b00)
                || (w_is_mmio && w_size != 2'b10) || w_wp_fault;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      w_idx[b] = addr_q[SW-1:0] + SW'(b);
      w_rb[b]  = mem_q[w_idx[b]];
    end
  end

  always_comb begin
    case (w_size)
      2'b00:   w_ld = {{24{sx_q & w_rb[0][7]}}, w_rb[0]};
      2'b01:   w_ld = {{16{sx_q & w_rb[1][7]}}, w_rb[1], w_rb[0]};
      default: w_ld = {w_rb[3], w_rb[2], w_rb[1], w_rb[0]};
    endcase
  end
  assign w_rdata = w_is_mmio ? w_mmio_rd : w_ld;

  assign w_done   = (state_q == S_BUSY) && (cnt_q == '0);
  assign w_commit = w_done && wr_q && !w_fault && !rst;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        state_d = S_BUSY;
        cnt_d   = CW'(RD_LAT - 1);
      end
      S_BUSY: if (cnt_q == '0) state_d = S_RESP;
              else             cnt_d   = cnt_q - 1'b1;
      S_RESP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      sx_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      mmio_q  <= '0;
      strb_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && req_valid) begin
        addr_q  <= address;
        wdata_q <= in_data;
        size_q  <= mem_size;
        sx_q    <= sz_ex;
        wr_q    <= wr_en;
      end
      rdata_q <= (w_done && !w_fault && !wr_q) ? w_rdata : '0;
      err_q   <= w_done && w_fault;
      for (int i = 0; i < MMIO_CH; i++) begin
        strb_q[i] <= w_commit && w_ch_hit[i];
        if (w_commit && w_ch_hit[i]) mmio_q[32*i +: 32] <= wdata_q;
      end
    end
  end

  // Storage is deliberately not reset; lanes beyond the access size are untouched.
  always_ff @(posedge clk) begin
    if (w_commit && !w_is_mmio) begin
      for (int b = 0; b < 4; b++) begin
        if (b == 0 || (b == 1 && size_q != 2'b00) || size_q == 2'b10)
          mem_q[w_idx[b]] <= wdata_q[8*b +: 8];
      end
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign resp_valid   = (state_q == S_RESP);
  assign out_data     = rdata_q;
  assign err          = err_q;
  assign mem_map_io   = mmio_q;
  assign mmio_wr_strb = strb_q;

endmodule

`default_nettype wire

// File: tb/tb_memory_mmio_ctrl.sv
// ============================================================================
// tb_memory_mmio_ctrl: scoreboard bench for memory_mmio_ctrl.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_memory_mmio_ctrl;

  localparam int RD_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] in_data = '0;
  logic [1:0]  mem_size = '0;
  logic        sz_ex = 1'b0;
  logic        resp_valid;
  logic [31:0] out_data;
  logic        err;
  logic [63:0] mem_map_io;
  logic [1:0]  mmio_wr_strb;

  int total = 0;
  int bad = 0;
  logic [32:0] sb [$];
  logic [1:0]  last_strb;
  logic [63:0] last_mmio;

  memory_mmio_ctrl #(
    .BUS_WIDTH(32), .MEM_BYTES(128), .IMEM_BYTES(32),
    .MMIO_BASE(120), .MMIO_CH(2), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .wr_en(wr_en), .address(address), .in_data(in_data), .mem_size(mem_size),
    .sz_ex(sz_ex), .resp_valid(resp_valid), .out_data(out_data), .err(err),
    .mem_map_io(mem_map_io), .mmio_wr_strb(mmio_wr_strb)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  // Drive one request, push its expectation, then pop and compare on the response.
  task automatic xfer(input string tag, input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [1:0] sz, input logic sx,
                      input logic [31:0] ed, input logic ee);
    int n;
    logic [32:0] e;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    req_valid = 1'b1; wr_en = wr; address = a; in_data = d; mem_size = sz; sz_ex = sx;
    sb.push_back({ee, ed});
    @(posedge clk);
    #1;
    req_valid = 1'b0; address = ~a; in_data = ~d; mem_size = ~sz; sz_ex = ~sx; wr_en = ~wr;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (resp_valid) break;
    end
    e = sb.pop_front();
    if (!resp_valid) begin
      check({tag, "_timeout"}, 64'(resp_valid), 64'd1);
    end else begin
      check({tag, "_lat"}, 64'(n), 64'(RD_LAT + 1));
      check({tag, "_data"}, 64'(out_data), 64'(e[31:0]));
      check({tag, "_err"}, 64'(err), 64'(e[32]));
      check({tag, "_rdy"}, 64'(req_ready), 64'd0);
      last_strb = mmio_wr_strb;
      last_mmio = mem_map_io;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(req_ready), 64'd1);
    check("rst_resp",  64'(resp_valid), 64'd0);
    check("rst_data",  64'(out_data), 64'd0);
    check("rst_err",   64'(err), 64'd0);
    check("rst_mmio",  mem_map_io, 64'd0);
    check("rst_strb",  64'(mmio_wr_strb), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    xfer("st40", 1, 32'h40, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0);
    xfer("ld40", 0, 32'h40, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);
    xfer("lb40", 0, 32'h40, 32'h0, 2'b00, 1, 32'hFFFFFFEF, 0);
    xfer("lb41", 0, 32'h41, 32'h0, 2'b00, 1, 32'hFFFFFFBE, 0);
    xfer("lb42", 0, 32'h42, 32'h0, 2'b00, 1, 32'hFFFFFFAD, 0);
    xfer("lb43", 0, 32'h43, 32'h0, 2'b00, 1, 32'hFFFFFFDE, 0);
    xfer("lhu42", 0, 32'h42, 32'h0, 2'b01, 0, 32'h0000DEAD, 0);
    xfer("lh40", 0, 32'h40, 32'h0, 2'b01, 1, 32'hFFFFBEEF, 0);
    xfer("lbu40", 0, 32'h40, 32'h0, 2'b00, 0, 32'h000000EF, 0);

    xfer("lh41", 0, 32'h41, 32'h0, 2'b01, 1, 32'h0, 1);
    xfer("lw42", 0, 32'h42, 32'h0, 2'b10, 0, 32'h0, 1);
    xfer("ld80", 0, 32'h80, 32'h0, 2'b10, 0, 32'h0, 1);
    xfer("st80", 1, 32'h80, 32'h1234, 2'b10, 0, 32'h0, 1);
    xfer("sw42", 1, 32'h42, 32'h0BADF00D, 2'b10, 0, 32'h0, 1);
    xfer("sz11", 1, 32'h40, 32'h0BADF00D, 2'b11, 0, 32'h0, 1);
    xfer("ld40b", 0, 32'h40, 32'h0, 2'b10, 0, 32'hDEADBEEF, 0);

    xfer("st44", 1, 32'h44, 32'h0, 2'b10, 0, 32'h0, 0);
    xfer("sb45", 1, 32'h45, 32'hFFFFFF77, 2'b00, 0, 32'h0, 0);
    xfer("sh46", 1, 32'h46, 32'hFFFF1234, 2'b01, 0, 32'h0, 0);
    xfer("ld44", 0, 32'h44, 32'h0, 2'b10, 0, 32'h12347700, 0);

    xfer("stmm1", 1, 32'h7C, 32'h5A, 2'b10, 0, 32'h0, 0);
    check("strb_pulse", 64'(last_strb), 64'd2);
    check("mmio_val", last_mmio, {32'h5A, 32'h0});
    @(negedge clk);
    check("strb_clear", 64'(mmio_wr_strb), 64'd0);
    xfer("ldmm1", 0, 32'h7C, 32'h0, 2'b10, 0, 32'h5A, 0);
    xfer("sbmm0", 1, 32'h78, 32'hFF, 2'b00, 0, 32'h0, 1);
    check("strb_none", 64'(last_strb), 64'd0);
    xfer("ldmm0", 0, 32'h78, 32'h0, 2'b10, 0, 32'h0, 0);

`ifdef IMEM_WP_EN
    xfer("st10wp", 1, 32'h10, 32'h80818283, 2'b10, 0, 32'h0, 1);
`else
    xfer("st10", 1, 32'h10, 32'h80818283, 2'b10, 0, 32'h0, 0);
    xfer("ld10", 0, 32'h10, 32'h0, 2'b00, 1, 32'h80818283, 0);
`endif

    xfer("st50", 1, 32'h50, 32'h11223344, 2'b10, 0, 32'h0, 0);
    @(negedge clk);
    req_valid = 1'b1; wr_en = 1'b1; address = 32'h50; in_data = 32'hAAAAAAAA; mem_size = 2'b10;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("abort_ready", 64'(req_ready), 64'd1);
    check("abort_resp",  64'(resp_valid), 64'd0);
    check("abort_mmio",  mem_map_io, 64'd0);
    repeat (3) @(negedge clk);
    check("abort_noresp", 64'(resp_valid), 64'd0);
    rst = 1'b0;
    xfer("ld50", 0, 32'h50, 32'h0, 2'b10, 0, 32'h11223344, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

endmodule

`default_nettype wire
